mem_xfer_ctrl: RTL

MEM_XFER_CTRL -- requirements
Module: mem_xfer_ctrl

---
 rtl/mem_xfer_pkg.sv | 20 ++
 rtl/mem_xfer_ctrl_if.sv | 37 +++
 rtl/xfer_idx_cnt.sv | 45 ++++
 rtl/mem_xfer_ctrl.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/mem_xfer_pkg.sv
// mem_xfer_pkg
//   Shared types for the memory transfer controller: the controller state
//   encoding and the number of states it uses.
//   No ports.
package mem_xfer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_GAP    = 3'd2,
    ST_CP_RD  = 3'd3,
    ST_CP_WR  = 3'd4,
    ST_VF_RD  = 3'd5,
    ST_VF_CMP = 3'd6,
    ST_DONE   = 3'd7
  } xfer_state_e;

  localparam int XFER_NUM_STATES = 8;

endpackage

// File: rtl/mem_xfer_ctrl_if.sv
// mem_xfer_ctrl_if
//   Bundle of the handshake and memory-side signals of mem_xfer_ctrl.
//   slave  : controller side (drives enables, addresses, status).
//   master : environment side (drives start/len/in_valid and memory read data).
//   Signals: start, len[ADDR_W:0], in_valid, in_ready, wea, addr_a, web,
//            addr_b, rd_data_a, rd_data_b, busy, done, mismatch, err_addr.
interface mem_xfer_ctrl_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
);

  logic              start;
  logic [ADDR_W:0]   len;
  logic              in_valid;
  logic              in_ready;
  logic              wea;
  logic [ADDR_W-1:0] addr_a;
  logic              web;
  logic [ADDR_W-1:0] addr_b;
  logic [DATA_W-1:0] rd_data_a;
  logic [DATA_W-1:0] rd_data_b;
  logic              busy;
  logic              done;
  logic              mismatch;
  logic [ADDR_W-1:0] err_addr;

  modport slave (
    input  start, len, in_valid, rd_data_a, rd_data_b,
    output in_ready, wea, addr_a, web, addr_b, busy, done, mismatch, err_addr
  );

  modport master (
    output start, len, in_valid, rd_data_a, rd_data_b,
    input  in_ready, wea, addr_a, web, addr_b, busy, done, mismatch, err_addr
  );

endinterface

// File: rtl/xfer_idx_cnt.sv
// xfer_idx_cnt
//   Word index counter for the transfer controller.
//   Ports: clk, reset (sync, active-high), clr_i (clear, wins over en_i),
//          en_i (increment), eff_len_i (current transfer length),
//          idx_o (count, ADDR_W+1 bits), last_o (idx_o == eff_len_i - 1).
module xfer_idx_cnt #(
  parameter int ADDR_W = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            clr_i,
  input  logic            en_i,
  input  logic [ADDR_W:0] eff_len_i,
  output logic [ADDR_W:0] idx_o,
  output logic            last_o
);

  logic [ADDR_W:0] idx_q;
  logic [ADDR_W:0] idx_d;

  // Next count: clear first, then increment, else hold.
  always_comb begin
    idx_d = idx_q;
    if (clr_i) begin
      idx_d = {(ADDR_W+1){1'b0}};
    end else if (en_i) begin
      idx_d = idx_q + {{ADDR_W{1'b0}}, 1'b1};
    end else begin
      idx_d = idx_q;
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (reset) begin
      idx_q <= {(ADDR_W+1){1'b0}};
    end else begin
      idx_q <= idx_d;
    end
  end

  assign idx_o  = idx_q;
  assign last_o = (idx_q == (eff_len_i - {{ADDR_W{1'b0}}, 1'b1}));

endmodule

// File: rtl/mem_xfer_ctrl.sv
// mem_xfer_ctrl
//   Loads a word stream into memory A, then copies A to B word by word
//   (read A one cycle, write B the next). Optional read-back verify of A
//   against B when the macro MXC_VERIFY_EN is defined.
//   Ports: clk, reset (sync, active-high), bus (mem_xfer_ctrl_if.slave):
//     start/len request, in_valid/in_ready load handshake, wea/addr_a,
//     web/addr_b memory controls, rd_data_a/rd_data_b read data,
//     busy/done status, mismatch/err_addr verify result.
module mem_xfer_ctrl
  import mem_xfer_pkg::*;
#(
  parameter int ADDR_W  = 4,
  parameter int DATA_W  = 8,
  parameter int MAX_LEN = 2**ADDR_W
) (
  input  logic            clk,
  input  logic            reset,
  mem_xfer_ctrl_if.slave  bus
);

  localparam logic [ADDR_W:0] MAX_LEN_C = (ADDR_W+1)'(MAX_LEN);

  xfer_state_e       state_q;
  xfer_state_e       state_d;
  logic [ADDR_W:0]   eff_len_q;
  logic [ADDR_W:0]   eff_len_d;
  logic [ADDR_W:0]   idx_s;
  logic              idx_clr_s;
  logic              idx_en_s;
  logic              idx_last_s;
  logic              start_acc_s;
  logic              in_ready_q;
  logic              web_q;
  logic              busy_q;
  logic              done_q;
  logic [ADDR_W-1:0] addr_a_s;
  logic [ADDR_W-1:0] addr_b_s;
  logic              idx_msb_unused_s;

  assign start_acc_s = (state_q == ST_IDLE) && bus.start;

  // idx restarts at each phase boundary; it counts accepted load words,
  // completed B writes and completed compares.
  assign idx_clr_s = start_acc_s
                   | (state_q == ST_GAP)
                   | ((state_q == ST_CP_WR) && idx_last_s)
                   | (state_q == ST_DONE);
  assign idx_en_s  = ((state_q == ST_LOAD) && bus.in_valid)
                   | (state_q == ST_CP_WR)
                   | (state_q == ST_VF_CMP);

  xfer_idx_cnt #(.ADDR_W(ADDR_W)) u_idx_cnt (
    .clk       (clk),
    .reset     (reset),
    .clr_i     (idx_clr_s),
    .en_i      (idx_en_s),
    .eff_len_i (eff_len_q),
    .idx_o     (idx_s),
    .last_o    (idx_last_s)
  );

  // Next-state and clamped length capture.
  always_comb begin
    state_d   = state_q;
    eff_len_d = eff_len_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          eff_len_d = (bus.len > MAX_LEN_C) ? MAX_LEN_C : bus.len;
          if (eff_len_d == {(ADDR_W+1){1'b0}}) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_LOAD;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LOAD: begin
        if (bus.in_valid && idx_last_s) begin
          state_d = ST_GAP;
        end else begin
          state_d = ST_LOAD;
        end
      end
      ST_GAP:   state_d = ST_CP_RD;
      ST_CP_RD: state_d = ST_CP_WR;
      ST_CP_WR: begin
        if (idx_last_s) begin
`ifdef MXC_VERIFY_EN
          state_d = ST_VF_RD;
`else
          state_d = ST_DONE;
`endif
        end else begin
          state_d = ST_CP_RD;
        end
      end
      ST_VF_RD: state_d = ST_VF_CMP;
      ST_VF_CMP: begin
        if (idx_last_s) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_VF_RD;
        end
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // State, length and registered status flags (decoded from the next state
  // so they line up with the state they describe).
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      eff_len_q  <= {(ADDR_W+1){1'b0}};
      in_ready_q <= 1'b0;
      web_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      eff_len_q  <= eff_len_d;
      in_ready_q <= (state_d == ST_LOAD);
      web_q      <= (state_d == ST_CP_WR);
      busy_q     <= (state_d != ST_IDLE);
      done_q     <= (state_d == ST_DONE);
    end
  end

  // Addresses come straight from the registered index, zero when unused.
  always_comb begin
    addr_a_s = {ADDR_W{1'b0}};
    addr_b_s = {ADDR_W{1'b0}};
    case (state_q)
      ST_LOAD, ST_CP_RD: addr_a_s = idx_s[ADDR_W-1:0];
      ST_CP_WR:          addr_b_s = idx_s[ADDR_W-1:0];
      ST_VF_RD, ST_VF_CMP: begin
        addr_a_s = idx_s[ADDR_W-1:0];
        addr_b_s = idx_s[ADDR_W-1:0];
      end
      default: begin
        addr_a_s = {ADDR_W{1'b0}};
        addr_b_s = {ADDR_W{1'b0}};
      end
    endcase
  end

  assign bus.in_ready = in_ready_q;
  // The write must follow the producer's valid in the same cycle.
  assign bus.wea      = in_ready_q & bus.in_valid;
  assign bus.web      = web_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.addr_a   = addr_a_s;
  assign bus.addr_b   = addr_b_s;

  // The index MSB only matters for the length compare inside the counter.
  assign idx_msb_unused_s = idx_s[ADDR_W];

`ifdef MXC_VERIFY_EN
  logic              mismatch_q;
  logic [ADDR_W-1:0] err_addr_q;

  // Sticky first-failure capture; data read in VF_RD is valid in VF_CMP.
  always_ff @(posedge clk) begin
    if (reset) begin
      mismatch_q <= 1'b0;
      err_addr_q <= {ADDR_W{1'b0}};
    end else if (start_acc_s) begin
      mismatch_q <= 1'b0;
      err_addr_q <= {ADDR_W{1'b0}};
    end else if ((state_q == ST_VF_CMP) && !mismatch_q &&
                 (bus.rd_data_a != bus.rd_data_b)) begin
      mismatch_q <= 1'b1;
      err_addr_q <= idx_s[ADDR_W-1:0];
    end else begin
      mismatch_q <= mismatch_q;
      err_addr_q <= err_addr_q;
    end
  end

  assign bus.mismatch = mismatch_q;
  assign bus.err_addr = err_addr_q;
`else
  logic rd_data_unused_s;

  assign rd_data_unused_s = ^{bus.rd_data_a, bus.rd_data_b};
  assign bus.mismatch     = 1'b0;
  assign bus.err_addr     = {ADDR_W{1'b0}};
`endif

endmodule
